// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// Width codes follow the main decoder's R_Width/W_Width encoding.
package mem_port_arbiter_pkg;

  localparam logic [1:0] WIDTH_WORD = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_BYTE = 2'd2;

  localparam int STREAK_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_D,
    BUSY_I,
    RESP_D,
    RESP_I
  } arb_state_e;

  function automatic logic [STREAK_W-1:0] sat_inc(
    input logic [STREAK_W-1:0] v,
    input logic [STREAK_W-1:0] lim
  );
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the port arbiter.
// slave = arbiter side, master = pipeline stages plus memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              IF_Req;
  logic [ADDR_W-1:0] IF_Addr;
  logic              IF_Ack;
  logic [31:0]       IF_RData;
  logic              IF_Stall;

  logic              DM_Req;
  logic              DM_Write;
  logic [1:0]        DM_Width;
  logic [ADDR_W-1:0] DM_Addr;
  logic [31:0]       DM_WData;
  logic              DM_Ack;
  logic [31:0]       DM_RData;
  logic              DM_Stall;
  logic              DM_Fault;

  logic              Mem_Req;
  logic              Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [3:0]        Mem_ByteEn;
  logic [31:0]       Mem_WData;
  logic              Mem_Ready;
  logic [31:0]       Mem_RData;

  modport slave (
    input  IF_Req, IF_Addr,
    output IF_Ack, IF_RData, IF_Stall,
    input  DM_Req, DM_Write, DM_Width,
    input  DM_Addr, DM_WData,
    output DM_Ack, DM_RData, DM_Stall,
    output DM_Fault,
    output Mem_Req, Mem_We, Mem_Addr,
    output Mem_ByteEn, Mem_WData,
    input  Mem_Ready, Mem_RData
  );

  modport master (
    output IF_Req, IF_Addr,
    input  IF_Ack, IF_RData, IF_Stall,
    output DM_Req, DM_Write, DM_Width,
    output DM_Addr, DM_WData,
    input  DM_Ack, DM_RData, DM_Stall,
    input  DM_Fault,
    input  Mem_Req, Mem_We, Mem_Addr,
    input  Mem_ByteEn, Mem_WData,
    output Mem_Ready, Mem_RData
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: enables, store replication, load extract.
// Little-endian lanes; width code 3 is always misaligned.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel  = addr_lo[1] ? rword[31:16]
                           : rword[15:0];
    byte_sel  = rword[{addr_lo, 3'b000} +: 8];
    byte_en   = '0;
    wdata_al  = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (width)
      WIDTH_WORD: begin
        byte_en   = 4'b1111;
        wdata_al  = wdata;
        rdata_ext = rword;
        misalign  = |addr_lo;
      end
      WIDTH_HALF: begin
        byte_en   = 4'b0011 << addr_lo;
        wdata_al  = {2{wdata[15:0]}};
        rdata_ext = {{16{half_sel[15]}},
                     half_sel};
        misalign  = addr_lo[0];
      end
      WIDTH_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_al  = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_sel[7]}},
                     byte_sel};
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/DM arbiter for one multi-cycle memory port with streak fairness.
// ARB_PERF_CNT_EN adds IF_StallCnt/DM_StallCnt stall counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        Clk,
  input  logic        Reset,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] IF_StallCnt,
  output logic [31:0] DM_StallCnt,
`endif
  mem_port_arbiter_if.slave bus
);

  localparam logic [STREAK_W-1:0] MAX_S =
    STREAK_W'(MAX_D_STREAK);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         mem_wd_q, mem_wd_d;
  logic                if_ack_q, if_ack_d;
  logic [31:0]         if_rd_q, if_rd_d;
  logic                dm_ack_q, dm_ack_d;
  logic [31:0]         dm_rd_q, dm_rd_d;
  logic                dm_flt_q, dm_flt_d;
  logic [1:0]          dw_q, dw_d;
  logic [1:0]          dlo_q, dlo_d;
  logic                dwr_q, dwr_d;

  logic                grant_d, grant_i;
  logic [1:0]          la_width, la_lo;
  logic [3:0]          la_be;
  logic [31:0]         la_wd, la_rd;
  logic                la_mis;

  // Live DM fields at issue, latched ones for the load extract.
  assign la_width = (state_q == IDLE)
                  ? bus.DM_Width : dw_q;
  assign la_lo    = (state_q == IDLE)
                  ? bus.DM_Addr[1:0] : dlo_q;

  mem_lane_align u_align (
    .width     (la_width),
    .addr_lo   (la_lo),
    .wdata     (bus.DM_WData),
    .rword     (bus.Mem_RData),
    .byte_en   (la_be),
    .wdata_al  (la_wd),
    .rdata_ext (la_rd),
    .misalign  (la_mis)
  );

  assign grant_d = bus.DM_Req
                 & ~(bus.IF_Req
                 & (streak_q == MAX_S));
  assign grant_i = bus.IF_Req & ~grant_d;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    be_d       = be_q;
    mem_wd_d   = mem_wd_q;
    if_ack_d   = 1'b0;
    if_rd_d    = if_rd_q;
    dm_ack_d   = 1'b0;
    dm_rd_d    = dm_rd_q;
    dm_flt_d   = 1'b0;
    dw_d       = dw_q;
    dlo_d      = dlo_q;
    dwr_d      = dwr_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_d: begin
            streak_d = bus.IF_Req
                     ? sat_inc(streak_q, MAX_S)
                     : '0;
            dw_d  = bus.DM_Width;
            dlo_d = bus.DM_Addr[1:0];
            dwr_d = bus.DM_Write;
            if (la_mis) begin
              state_d  = RESP_D;
              dm_ack_d = 1'b1;
              dm_flt_d = 1'b1;
              dm_rd_d  = '0;
            end else begin
              state_d    = BUSY_D;
              mem_req_d  = 1'b1;
              mem_we_d   = bus.DM_Write;
              mem_addr_d = {bus.DM_Addr[ADDR_W-1:2],
                            2'b00};
              be_d       = la_be;
              mem_wd_d   = la_wd;
            end
          end
          grant_i: begin
            streak_d   = '0;
            state_d    = BUSY_I;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {bus.IF_Addr[ADDR_W-1:2],
                          2'b00};
            be_d       = 4'b1111;
            mem_wd_d   = '0;
          end
          default: streak_d = '0;
        endcase
      end
      BUSY_D, BUSY_I: begin
        if (bus.Mem_Ready) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = '0;
          be_d       = '0;
          mem_wd_d   = '0;
          if (state_q == BUSY_D) begin
            state_d  = RESP_D;
            dm_ack_d = 1'b1;
            dm_rd_d  = dwr_q ? '0 : la_rd;
          end else begin
            state_d  = RESP_I;
            if_ack_d = 1'b1;
            if_rd_d  = bus.Mem_RData;
          end
        end
      end
      RESP_D, RESP_I: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      be_q       <= '0;
      mem_wd_q   <= '0;
      if_ack_q   <= 1'b0;
      if_rd_q    <= '0;
      dm_ack_q   <= 1'b0;
      dm_rd_q    <= '0;
      dm_flt_q   <= 1'b0;
      dw_q       <= '0;
      dlo_q      <= '0;
      dwr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      be_q       <= be_d;
      mem_wd_q   <= mem_wd_d;
      if_ack_q   <= if_ack_d;
      if_rd_q    <= if_rd_d;
      dm_ack_q   <= dm_ack_d;
      dm_rd_q    <= dm_rd_d;
      dm_flt_q   <= dm_flt_d;
      dw_q       <= dw_d;
      dlo_q      <= dlo_d;
      dwr_q      <= dwr_d;
    end
  end

  assign bus.IF_Ack     = if_ack_q;
  assign bus.IF_RData   = if_rd_q;
  assign bus.IF_Stall   = bus.IF_Req & ~if_ack_q;
  assign bus.DM_Ack     = dm_ack_q;
  assign bus.DM_RData   = dm_rd_q;
  assign bus.DM_Stall   = bus.DM_Req & ~dm_ack_q;
  assign bus.DM_Fault   = dm_flt_q;
  assign bus.Mem_Req    = mem_req_q;
  assign bus.Mem_We     = mem_we_q;
  assign bus.Mem_Addr   = mem_addr_q;
  assign bus.Mem_ByteEn = be_q;
  assign bus.Mem_WData  = mem_wd_q;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IF_StallCnt <= '0;
      DM_StallCnt <= '0;
    end else begin
      if (bus.IF_Stall)
        IF_StallCnt <= IF_StallCnt + 32'd1;
      if (bus.DM_Stall)
        DM_StallCnt <= DM_StallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus random traffic
// against a transaction-level model checked every cycle.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_cnt, dm_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W(32),
    .MAX_D_STREAK(MAX)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
`ifdef ARB_PERF_CNT_EN
    .IF_StallCnt(if_cnt),
    .DM_StallCnt(dm_cnt),
`endif
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endfunction

  // Memory model: Mem_Ready after a chosen number of cycles.
  bit          mem_fix = 0;
  int          mem_delay = 0;
  logic [31:0] mem_data = '0;

  initial begin
    int cnt;
    cnt = -1;
    bus.Mem_Ready = 1'b0;
    bus.Mem_RData = '0;
    forever begin
      @(posedge Clk);
      #1;
      bus.Mem_Ready = 1'b0;
      if (Reset || !bus.Mem_Req) cnt = -1;
      else begin
        if (cnt < 0)
          cnt = mem_fix ? mem_delay
                        : int'($urandom_range(0, 3));
        if (cnt == 0) begin
          bus.Mem_Ready = 1'b1;
          bus.Mem_RData = mem_fix ? mem_data : $urandom;
          cnt = -1;
        end else cnt--;
      end
    end
  end

  // Transaction-level reference model.
  typedef struct {
    bit          dm;
    bit          wr;
    bit [1:0]    w;
    bit [31:0]   a;
    bit [31:0]   wd;
  } txn_t;

  function automatic int nbytes(input bit [1:0] w);
    return (w == 0) ? 4 : (w == 1) ? 2 : (w == 2) ? 1 : 0;
  endfunction

  function automatic bit bad(input bit [1:0] w,
                             input bit [31:0] a);
    if (w == 3) return 1'b1;
    return (a % nbytes(w)) != 0;
  endfunction

  function automatic logic [3:0] ebe(input txn_t t);
    int v;
    if (!t.dm) return 4'hF;
    v = ((1 << nbytes(t.w)) - 1) << (t.a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] ewd(input txn_t t);
    case (nbytes(t.w))
      2: return (t.wd & 32'hFFFF) * 32'h0001_0001;
      1: return (t.wd & 32'hFF) * 32'h0101_0101;
      default: return t.wd;
    endcase
  endfunction

  function automatic logic [31:0] erd(input txn_t t,
                                      input logic [31:0] r);
    logic [31:0] sh;
    if (!t.dm) return r;
    sh = r >> (8 * (t.a % 4));
    case (nbytes(t.w))
      2: begin
        sh = sh & 32'hFFFF;
        if (sh >= 32'h8000) sh = sh | 32'hFFFF_0000;
        return sh;
      end
      1: begin
        sh = sh & 32'hFF;
        if (sh >= 32'h80) sh = sh | 32'hFFFF_FF00;
        return sh;
      end
      default: return r;
    endcase
  endfunction

  txn_t        cur;
  bit          m_mem = 0, m_ack = 0, m_flt = 0;
  logic [31:0] m_rd = '0;
  int          streak = 0;

  initial begin
    bit pd, ia, da;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        m_mem = 0; m_ack = 0; streak = 0;
        chk("rst_ctl", {26'd0, bus.IF_Ack, bus.DM_Ack,
            bus.DM_Fault, bus.Mem_Req, bus.Mem_We, 1'b0}, 0);
        chk("rst_be", {28'd0, bus.Mem_ByteEn}, 0);
        chk("rst_addr", bus.Mem_Addr, 0);
      end else begin
        ia = m_ack && !cur.dm;
        da = m_ack && cur.dm;
        chk("m_mem_req", {31'd0, bus.Mem_Req}, {31'd0, m_mem});
        if (m_mem) begin
          chk("m_we", {31'd0, bus.Mem_We},
              {31'd0, cur.dm && cur.wr});
          chk("m_addr", bus.Mem_Addr, cur.a & ~32'h3);
          chk("m_be", {28'd0, bus.Mem_ByteEn},
              {28'd0, ebe(cur)});
          if (cur.dm && cur.wr)
            chk("m_wdata", bus.Mem_WData, ewd(cur));
        end
        chk("m_if_ack", {31'd0, bus.IF_Ack}, {31'd0, ia});
        chk("m_dm_ack", {31'd0, bus.DM_Ack}, {31'd0, da});
        chk("m_fault", {31'd0, bus.DM_Fault},
            {31'd0, da && m_flt});
        chk("m_if_stall", {31'd0, bus.IF_Stall},
            {31'd0, bus.IF_Req && !ia});
        chk("m_dm_stall", {31'd0, bus.DM_Stall},
            {31'd0, bus.DM_Req && !da});
        if (ia) chk("m_if_rdata", bus.IF_RData, m_rd);
        if (da && !cur.wr)
          chk("m_dm_rdata", bus.DM_RData, m_rd);
        if (m_ack) m_ack = 0;
        else if (m_mem) begin
          if (bus.Mem_Ready) begin
            m_mem = 0; m_ack = 1; m_flt = 0;
            m_rd = erd(cur, bus.Mem_RData);
          end
        end else begin
          pd = bus.DM_Req && !(bus.IF_Req && streak == MAX);
          if (pd) begin
            streak = bus.IF_Req
                   ? ((streak < MAX) ? streak + 1 : MAX) : 0;
            cur.dm = 1; cur.wr = bus.DM_Write;
            cur.w = bus.DM_Width; cur.a = bus.DM_Addr;
            cur.wd = bus.DM_WData;
            if (bad(cur.w, cur.a)) begin
              m_ack = 1; m_flt = 1; m_rd = '0;
            end else m_mem = 1;
          end else if (bus.IF_Req) begin
            streak = 0;
            cur.dm = 0; cur.wr = 0; cur.w = 0;
            cur.a = bus.IF_Addr; cur.wd = 0;
            m_mem = 1;
          end else streak = 0;
        end
      end
    end
  end

  task automatic wait_for(input int sel, output bit ok);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge Clk);
      ok = (sel == 0) ? bus.Mem_Req
         : (sel == 1) ? bus.DM_Ack : bus.IF_Ack;
    end
  endtask

  task automatic new_dm();
    int r;
    bit [1:0] w;
    bit [31:0] a;
    r = $urandom_range(0, 7);
    w = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
    a = $urandom & 32'hFFFC;
    if ($urandom_range(0, 3) == 0) a = a | $urandom_range(0, 3);
    else if (w == 1) a = a | (2 * $urandom_range(0, 1));
    else if (w == 2) a = a | $urandom_range(0, 3);
    bus.DM_Req = 1; bus.DM_Write = 1'($urandom_range(0, 1));
    bus.DM_Width = w; bus.DM_Addr = a; bus.DM_WData = $urandom;
  endtask

  initial begin
    bit ok, prev, dack, iack;
    bit [9:0] got;
    int ng;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] c0;
    int k;
`endif
    bus.IF_Req = 0; bus.IF_Addr = '0;
    bus.DM_Req = 0; bus.DM_Write = 0; bus.DM_Width = 0;
    bus.DM_Addr = '0; bus.DM_WData = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 0;
    @(negedge Clk);
    chk("reset_state", {29'd0, bus.Mem_Req, bus.IF_Ack,
        bus.DM_Ack}, 0);

    // IF fetch, memory answers 2 cycles after Mem_Req
    mem_fix = 1; mem_delay = 2; mem_data = 32'h8C08_0004;
    @(posedge Clk); #1;
    bus.IF_Req = 1; bus.IF_Addr = 32'h40;
    for (int c = 0; c <= 4; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        chk("t1_memreq", {31'd0, bus.Mem_Req}, 1);
        chk("t1_addr", bus.Mem_Addr, 32'h40);
      end
      if (c < 4) begin
        chk("t1_stall", {31'd0, bus.IF_Stall}, 1);
        chk("t1_noack", {31'd0, bus.IF_Ack}, 0);
      end else begin
        chk("t1_ack", {31'd0, bus.IF_Ack}, 1);
        chk("t1_rdata", bus.IF_RData, 32'h8C08_0004);
        chk("t1_stall_end", {31'd0, bus.IF_Stall}, 0);
      end
    end
    @(posedge Clk); #1 bus.IF_Req = 0;

    // byte store at 0x103
    @(posedge Clk); #1;
    bus.DM_Req = 1; bus.DM_Write = 1; bus.DM_Width = 2;
    bus.DM_Addr = 32'h103; bus.DM_WData = 32'hA5;
    wait_for(0, ok);
    chk("t2_memreq_seen", {31'd0, ok}, 1);
    chk("t2_addr", bus.Mem_Addr, 32'h100);
    chk("t2_be", {28'd0, bus.Mem_ByteEn}, 32'h8);
    chk("t2_wdata", bus.Mem_WData, 32'hA5A5_A5A5);
    chk("t2_we", {31'd0, bus.Mem_We}, 1);
    wait_for(1, ok);
    chk("t2_ack_seen", {31'd0, ok}, 1);
    @(posedge Clk); #1 bus.DM_Req = 0;

    // half load at 0x202, then misaligned at 0x201
    mem_data = 32'h8001_1234;
    @(posedge Clk); #1;
    bus.DM_Req = 1; bus.DM_Write = 0; bus.DM_Width = 1;
    bus.DM_Addr = 32'h202;
    wait_for(1, ok);
    chk("t3_ack_seen", {31'd0, ok}, 1);
    chk("t3_rdata", bus.DM_RData, 32'hFFFF_8001);
    chk("t3_nofault", {31'd0, bus.DM_Fault}, 0);
    @(posedge Clk); #1 bus.DM_Req = 0;
    @(posedge Clk); #1;
    bus.DM_Req = 1; bus.DM_Addr = 32'h201;
    @(negedge Clk);
    chk("t3f_noack0", {31'd0, bus.DM_Ack}, 0);
    @(negedge Clk);
    chk("t3f_ack", {31'd0, bus.DM_Ack}, 1);
    chk("t3f_fault", {31'd0, bus.DM_Fault}, 1);
    chk("t3f_rdata", bus.DM_RData, 0);
    chk("t3f_nomem", {31'd0, bus.Mem_Req}, 0);
    @(posedge Clk); #1 bus.DM_Req = 0;

    // both held: streak fairness
    mem_fix = 0;
    @(posedge Clk); #1;
    bus.IF_Req = 1; bus.IF_Addr = 32'h1000;
    bus.DM_Req = 1; bus.DM_Write = 0; bus.DM_Width = 0;
    bus.DM_Addr = 32'h2000;
    got = '0; ng = 0; prev = 0;
    for (int c = 0; c < 400 && ng < 10; c++) begin
      @(negedge Clk);
      if (bus.Mem_Req && !prev) begin
        got[ng] = (bus.Mem_Addr == 32'h1000);
        ng++;
      end
      prev = bus.Mem_Req;
    end
    chk("t4_ngrants", ng, 10);
    chk("t4_order", {22'd0, got}, 32'b10_0001_0000);
    wait_for(2, ok);
    chk("t4_last_ack", {31'd0, ok}, 1);
    @(posedge Clk); #1;
    bus.IF_Req = 0; bus.DM_Req = 0;

    // async reset during BUSY_D
    mem_fix = 1; mem_delay = 20;
    @(posedge Clk); #1;
    bus.DM_Req = 1; bus.DM_Width = 0; bus.DM_Addr = 32'h300;
    wait_for(0, ok);
    chk("t5_busy", {31'd0, ok}, 1);
    @(posedge Clk); #3;
    Reset = 1; bus.DM_Req = 0;
    bus.IF_Req = 1; bus.IF_Addr = 32'h500;
    #1;
    chk("t5_rst_ctl", {27'd0, bus.IF_Ack, bus.DM_Ack,
        bus.DM_Fault, bus.Mem_Req, bus.Mem_We}, 0);
    chk("t5_rst_addr", bus.Mem_Addr, 0);
    chk("t5_rst_be", {28'd0, bus.Mem_ByteEn}, 0);
    @(posedge Clk); #1;
    Reset = 0; mem_fix = 0;
    wait_for(0, ok);
    chk("t5_grant_seen", {31'd0, ok}, 1);
    chk("t5_grant_if", bus.Mem_Addr, 32'h500);
    wait_for(2, ok);
    chk("t5_if_ack", {31'd0, ok}, 1);
    @(posedge Clk); #1 bus.IF_Req = 0;

`ifdef ARB_PERF_CNT_EN
    mem_fix = 1; mem_delay = 1;
    @(posedge Clk); #1;
    bus.IF_Req = 1; bus.IF_Addr = 32'h80;
    @(negedge Clk);
    c0 = if_cnt;
    k = 0;
    for (int c = 1; c < 32 && k == 0; c++) begin
      @(negedge Clk);
      if (bus.IF_Ack) k = c;
    end
    chk("t6_latency", k, 3);
    chk("t6_stallcnt", if_cnt - c0, k);
    @(posedge Clk); #1 bus.IF_Req = 0;
    mem_fix = 0;
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      dack = bus.DM_Ack; iack = bus.IF_Ack;
      @(posedge Clk); #1;
      if (!bus.DM_Req || dack) begin
        if ($urandom_range(0, 1) == 0) new_dm();
        else bus.DM_Req = 0;
      end
      if (!bus.IF_Req || iack) begin
        bus.IF_Req = 1'($urandom_range(0, 1));
        bus.IF_Addr = $urandom & 32'hFFFF;
      end
    end
    bus.IF_Req = 0; bus.DM_Req = 0;
    repeat (30) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle unified memory port between instruction fetch (IF, read-only, word) and the data-memory stage (DM, read/write, word/half/byte).
- Generates byte enables, lane-aligns write data, and extracts/sign-extends read data.
- Produces per-requester stall signals for the pipeline.
- Sits between the IF/MEM pipeline stages and the memory model; DM width codes match the main decoder's R_Width/W_Width encoding: 0=word, 1=half, 2=byte.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- MAX_D_STREAK, 4, consecutive DM grants allowed while IF waits before IF is forced (range 1..15).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IF_Req  in  1  fetch request; held stable until IF_Ack.
- IF_Addr  in  ADDR_W  fetch address.
- IF_Ack  out  1  one-cycle completion pulse.
- IF_RData  out  32  instruction word, valid with IF_Ack.
- IF_Stall  out  1  IF_Req & ~IF_Ack.
- DM_Req  in  1  data request; held stable until DM_Ack.
- DM_Write  in  1  1=store, 0=load.
- DM_Width  in  2  0=word, 1=half, 2=byte, 3=illegal.
- DM_Addr  in  ADDR_W  data address.
- DM_WData  in  32  store data, right-justified.
- DM_Ack  out  1  one-cycle completion pulse.
- DM_RData  out  32  sign-extended load data, valid with DM_Ack.
- DM_Stall  out  1  DM_Req & ~DM_Ack.
- DM_Fault  out  1  pulses with DM_Ack on misaligned or illegal-width access.
- Mem_Req  out  1  high from issue until Mem_Ready.
- Mem_We  out  1  write strobe qualifier.
- Mem_Addr  out  ADDR_W  word-aligned address (bits [1:0]=0).
- Mem_ByteEn  out  4  lane enables.
- Mem_WData  out  32  lane-aligned store data.
- Mem_Ready  in  1  one-cycle completion from memory.
- Mem_RData  in  32  read word, valid with Mem_Ready.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, streak counter=0. Reset mid-access abandons it silently, with no ack; the memory shares the same Reset.
- FSM states:
  - IDLE: samples requests at the clock edge.
    - None pending -> IDLE.
    - DM only -> BUSY_D.
    - IF only -> BUSY_I.
    - Both pending: DM wins unless streak==MAX_D_STREAK, in which case IF wins.
    - A DM request that is misaligned or has an illegal width goes to RESP_D directly, with no memory access and DM_Fault=1.
  - BUSY_x: Mem_Req and the address/enable/data lines are registered and held constant. Stays in BUSY_x until Mem_Ready, then -> RESP_x, capturing Mem_RData.
  - RESP_x: the matching Ack is 1 for exactly one cycle with RData valid; -> IDLE.
- Streak counter:
  - Increments on each DM grant made while IF_Req=1.
  - Clears on any IF grant, or when IF_Req=0 in IDLE.
  - Saturates at MAX_D_STREAK.
- Minimum latency: request seen at edge N, Mem_Req high in cycle N+1, Mem_Ready at edge M, Ack in cycle M+1. One access per at least 3 cycles.
- Requests are ignored during BUSY/RESP. A request still high in the RESP cycle is treated as new at the following IDLE sample.
- Alignment rules:
  - Word requires addr[1:0]==0.
  - Half requires addr[0]==0.
  - Byte has no alignment requirement.
  - DM_Width==3 faults.
  - IF addr[1:0]!=0 is ignored: treated as word-aligned, no fault.
- Byte enables, little-endian, o = addr[1:0]:
  - Word: ByteEn=4'b1111.
  - Half: 4'b0011<<o; WData = {2{wdata[15:0]}}.
  - Byte: 4'b0001<<o; WData = {4{wdata[7:0]}}.
- Loads: Mem_We=0 and ByteEn still driven. DM_RData is the selected lane(s), sign-extended to 32 bits. Faulted loads return 0.
- Outputs are registered, except the combinational Stall signals.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds output ports IF_StallCnt[31:0] and DM_StallCnt[31:0]. Each increments on every cycle its Stall output is 1, wraps at 2^32, and clears on Reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - Width codes WIDTH_WORD=0, WIDTH_HALF=1, WIDTH_BYTE=2.
  - FSM state encoding: IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I.
- One sub-module, mem_lane_align (combinational). Inputs: width, addr[1:0], write data, read word. Outputs: ByteEn, aligned WData, extracted sign-extended RData, misalign flag.

Test Plan:
- IF_Req=1, addr 0x40; memory returns 0x8C080004 with Mem_Ready 2 cycles after Mem_Req -> IF_Ack in cycle 4 after request, IF_RData=0x8C080004, IF_Stall high through cycle 3.
- DM store byte, addr 0x103, WData=0x000000A5 -> Mem_Addr=0x100, ByteEn=4'b1000, Mem_WData=0xA5A5A5A5, Mem_We=1.
- DM load half, addr 0x202; memory word 0x8001_1234 -> DM_RData=0xFFFF8001. Same load at addr 0x201 -> DM_Fault=1, no Mem_Req, DM_RData=0.
- IF and DM held continuously with MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Reset asserted while in BUSY_D -> all outputs 0 asynchronously, no DM_Ack; after release with IF_Req=1 -> next grant is IF.
- ARB_PERF_CNT_EN defined, 3-cycle-latency IF access -> IF_StallCnt increments by exactly (Ack cycle − request cycle).
